apb4_master_bridge: RTL and testbench
=====================================

// Module: apb4_master_bridge
// PURPOSE
//  Converts a simple valid/ready request/response port into APB4 initiator transfers.
//  It is the initiator end of the APB4 bus that our peripheral responders (info regs, timers, ...) sit on.
//  Each request produces one SETUP+ACCESS transfer, then one registered response.
//  A timeout counter guards against responders that never assert pready.
// PARAMETERS
//  ADDR_WIDTH   32  paddr/req_addr width
//  DATA_WIDTH   32  pwdata/prdata width; must be 32 (byte lanes = DATA_WIDTH/8)
//  TIMEOUT_CYC  256 max ACCESS cycles before forced termination; 0 disables timeout
// PORTS
//  hclk         in   1           clock; all logic on rising edge
//  hrst         in   1           reset; synchronous, active-high
//  req_valid    in   1           request present
//  req_ready    out  1           bridge accepts request (handshake = valid & ready)
//  req_write    in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  byte address; must be word-aligned
//  req_wdata    in   DATA_WIDTH  write data
//  req_strb     in   DATA_WIDTH/8  write byte strobes
//  req_prot     in   3           forwarded to pprot
//  rsp_valid    out  1           response present; held until rsp_ready
//  rsp_ready    in   1           consumer takes response
//  rsp_rdata    out  DATA_WIDTH  read data (0 for writes/errors)
//  rsp_err      out  1           pslverr, misalign or timeout
//  rsp_timeout  out  1           error cause was timeout
//  paddr        out  ADDR_WIDTH  APB4 address
//  pprot        out  3           APB4 protection
//  psel         out  1           APB4 select
//  penable      out  1           APB4 enable
//  pwrite       out  1           APB4 direction
//  pwdata       out  DATA_WIDTH  APB4 write data
//  pstrb        out  DATA_WIDTH/8  APB4 write strobes
//  pready       in   1           APB4 ready
//  prdata       in   DATA_WIDTH  APB4 read data
//  pslverr      in   1           APB4 error
// BEHAVIOUR
//  - Reset: state IDLE. req_ready=1, rsp_valid=0, psel=penable=0.
//    paddr/pwdata/pstrb/pprot/pwrite=0. rsp_* data=0. Timeout count=0.
//  - FSM IDLE->SETUP->ACCESS->RESP->IDLE. All APB outputs are registered.
//  - IDLE: req_ready=1 only here.
//    On handshake with aligned addr: capture request, go SETUP.
//    If req_addr[1:0]!=0: no APB transfer; go RESP with rsp_err=1, rdata=0.
//  - SETUP (1 cycle): psel=1, penable=0, all address/control/data valid. Then go ACCESS.
//  - ACCESS: psel=1, penable=1; outputs stable.
//    On pready=1: capture prdata (reads only) and pslverr, go RESP.
//    Next edge psel=penable=0.
//  - Timeout: count increments each ACCESS cycle with pready=0.
//    When TIMEOUT_CYC!=0 and count==TIMEOUT_CYC-1 with pready=0: abort.
//    psel/penable drop next edge; go RESP with rsp_err=1, rsp_timeout=1, rdata=0.
//    Count clears on entering SETUP.
//  - Reads: pstrb=0, pwdata=0. Writes: pstrb=req_strb, pwdata=req_wdata.
//    rsp_rdata=0 for writes.
//  - RESP: rsp_valid=1, fields stable until rsp_ready; on handshake go IDLE.
//  - Timing (no waits): accept at edge 0.
//    SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3, next req_ready cycle 4
//    (if rsp_ready=1 in cycle 3).
//  - Exactly one outstanding transfer. req_* is ignored outside IDLE.
//  - pready/pslverr/prdata are ignored outside ACCESS.
//  - Sync hrst in any state (incl. mid-ACCESS): all outputs take reset values at that edge.
//    No response is generated for the aborted transfer.
// STRUCTURE
//  - apb4_master_pkg: state enum {IDLE,SETUP,ACCESS,RESP} (2-bit), ALIGN_MASK constant,
//    rsp struct {rdata,err,timeout}.
//  - Timeout counter width $clog2(TIMEOUT_CYC+1), inline; no sub-module needed.
//  - Single module: FSM + capture registers.
// TESTING
//  1. Write 0x10 data 0xA5A5_5A5A strb 0xF, pready=1:
//     psel/penable pattern 10->11 over 2 cycles, pstrb=0xF, rsp_err=0 in cycle 3.
//  2. Read 0x04, pready low 3 ACCESS cycles then high with prdata 0xDEAD_BEEF:
//     rsp_rdata=0xDEAD_BEEF, ACCESS lasts 4 cycles, outputs stable throughout.
//  3. Read with pslverr=1 at pready:
//     rsp_err=1, rsp_timeout=0. Read request pstrb=0 checked during SETUP/ACCESS.
//  4. TIMEOUT_CYC=8, pready stuck 0:
//     abort after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, psel=0 next cycle.
//  5. req_addr=0x13:
//     psel never asserts, rsp_valid one cycle after accept with rsp_err=1.
//     rsp_ready held 0 for 5 cycles: response held and req_ready=0.
//  6. hrst asserted in 2nd ACCESS cycle:
//     psel/penable/rsp_valid=0 after edge, req_ready=1, no spurious response.

Source files
------------

// File: rtl/apb4_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb4_master_pkg
//  Description : Shared types and constants for the APB4 master bridge.
//                - state_t    : bridge FSM states (2-bit encoding)
//                - ALIGN_MASK : low address bits that must be zero
//                - rsp_t      : registered response {rdata, err, timeout}
//  Revision    : 1.0 - initial release
// ============================================================================
package apb4_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Word alignment: both low byte-address bits must be clear.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    localparam int RSP_DATA_W = 32;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage : apb4_master_pkg
`default_nettype wire

// File: rtl/apb4_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb4_master_bridge
//  Description : Converts a valid/ready request port into single APB4
//                SETUP+ACCESS transfers and returns one registered response
//                per request. A timeout counter terminates transfers whose
//                responder never raises pready.
//  Ports       : hclk, hrst             - clock, synchronous active-high reset
//                req_valid/req_ready    - request handshake
//                req_write/addr/wdata/strb/prot - request fields
//                rsp_valid/rsp_ready    - response handshake
//                rsp_rdata/err/timeout  - response fields
//                paddr/pprot/psel/penable/pwrite/pwdata/pstrb - APB4 outputs
//                pready/prdata/pslverr  - APB4 inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module apb4_master_bridge
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                    hclk,
    input  logic                    hrst,
    // request port
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    // response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    // APB4 initiator
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    // A zero-cycle timeout still needs a 1-bit counter to keep widths legal.
    localparam int c_cnt_w = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam bit c_to_en = (TIMEOUT_CYC != 0);

    state_t                  r_state,   w_state_nxt;
    logic                    r_psel,    w_psel_nxt;
    logic                    r_penable, w_penable_nxt;
    logic [ADDR_WIDTH-1:0]   r_paddr,   w_paddr_nxt;
    logic [2:0]              r_pprot,   w_pprot_nxt;
    logic                    r_pwrite,  w_pwrite_nxt;
    logic [DATA_WIDTH-1:0]   r_pwdata,  w_pwdata_nxt;
    logic [DATA_WIDTH/8-1:0] r_pstrb,   w_pstrb_nxt;
    logic [c_cnt_w-1:0]      r_cnt,     w_cnt_nxt;
    rsp_t                    r_rsp,     w_rsp_nxt;

    logic w_misaligned;
    logic w_to_hit;

    assign w_misaligned = ((req_addr[1:0] & ALIGN_MASK) != 2'b00);
    assign w_to_hit     = c_to_en && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pprot   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_cnt     <= '0;
            r_rsp     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pprot   <= w_pprot_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_pstrb   <= w_pstrb_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rsp     <= w_rsp_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_paddr_nxt   = r_paddr;
        w_pprot_nxt   = r_pprot;
        w_pwrite_nxt  = r_pwrite;
        w_pwdata_nxt  = r_pwdata;
        w_pstrb_nxt   = r_pstrb;
        w_cnt_nxt     = r_cnt;
        w_rsp_nxt     = r_rsp;

        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misaligned) begin
                        // Rejected without touching the bus.
                        w_state_nxt = RESP;
                        w_rsp_nxt   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
                    end else begin
                        w_state_nxt   = SETUP;
                        w_psel_nxt    = 1'b1;
                        w_penable_nxt = 1'b0;
                        w_paddr_nxt   = req_addr;
                        w_pprot_nxt   = req_prot;
                        w_pwrite_nxt  = req_write;
                        // Reads drive zero data and strobes on the bus.
                        w_pwdata_nxt  = req_write ? req_wdata : '0;
                        w_pstrb_nxt   = req_write ? req_strb  : '0;
                        w_cnt_nxt     = '0;
                    end
                end
            end

            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
            end

            ACCESS: begin
                if (pready) begin
                    w_state_nxt   = RESP;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_rsp_nxt.rdata   = (!r_pwrite && !pslverr) ? prdata : '0;
                    w_rsp_nxt.err     = pslverr;
                    w_rsp_nxt.timeout = 1'b0;
                end else if (w_to_hit) begin
                    w_state_nxt   = RESP;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_rsp_nxt     = '{rdata: '0, err: 1'b1, timeout: 1'b1};
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // ------------------------------------------------------------------
    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rdata   = r_rsp.rdata;
    assign rsp_err     = r_rsp.err;
    assign rsp_timeout = r_rsp.timeout;

    assign paddr   = r_paddr;
    assign pprot   = r_pprot;
    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign pwdata  = r_pwdata;
    assign pstrb   = r_pstrb;

endmodule : apb4_master_bridge
`default_nettype wire

// File: tb/tb_apb4_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb4_master_bridge
//  Description : Directed self-checking bench for apb4_master_bridge.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_master_bridge;

    logic        hclk;
    logic        hrst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int total;
    int passed;

    apb4_master_bridge #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .hclk        (hclk),
        .hrst        (hrst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pprot       (pprot),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Present a request in the current (falling-edge) cycle.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        repeat (2) @(negedge hclk);
        total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%0h exp=1", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); else passed++;
        total++; if ({psel, penable} !== 2'b00) $display("FAIL rst_psel_pen got=%b exp=00", {psel, penable}); else passed++;
        total++; if ({paddr, pwdata, pstrb, pprot, pwrite} !== '0)
            $display("FAIL rst_apb_fields got=%h/%h/%h/%h/%h exp=0", paddr, pwdata, pstrb, pprot, pwrite); else passed++;
        total++; if ({rsp_rdata, rsp_err, rsp_timeout} !== '0)
            $display("FAIL rst_rsp_fields got=%h/%h/%h exp=0", rsp_rdata, rsp_err, rsp_timeout); else passed++;
        hrst = 1'b0;
    endtask

    task automatic test_write();
        @(negedge hclk);                                   // cycle 0
        issue(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 3'b010);
        total++; if (req_ready !== 1'b1) $display("FAIL wr_c0_ready got=%0h exp=1", req_ready); else passed++;
        @(negedge hclk);                                   // cycle 1: SETUP
        req_valid = 1'b0;
        total++; if ({psel, penable} !== 2'b10) $display("FAIL wr_setup_pattern got=%b exp=10", {psel, penable}); else passed++;
        total++; if (paddr !== 32'h10) $display("FAIL wr_paddr got=%h exp=00000010", paddr); else passed++;
        total++; if (pwdata !== 32'hA5A5_5A5A) $display("FAIL wr_pwdata got=%h exp=a5a55a5a", pwdata); else passed++;
        total++; if ({pwrite, pstrb, pprot} !== {1'b1, 4'hF, 3'b010})
            $display("FAIL wr_ctrl got=%b/%h/%b exp=1/f/010", pwrite, pstrb, pprot); else passed++;
        total++; if (req_ready !== 1'b0) $display("FAIL wr_busy_ready got=%0h exp=0", req_ready); else passed++;
        @(negedge hclk);                                   // cycle 2: ACCESS
        total++; if ({psel, penable} !== 2'b11) $display("FAIL wr_access_pattern got=%b exp=11", {psel, penable}); else passed++;
        pready = 1'b1;
        prdata = 32'h1234_5678;
        @(negedge hclk);                                   // cycle 3: RESP
        pready = 1'b0;
        total++; if (rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid got=%0h exp=1", rsp_valid); else passed++;
        total++; if ({rsp_err, rsp_timeout} !== 2'b00) $display("FAIL wr_rsp_err got=%b exp=00", {rsp_err, rsp_timeout}); else passed++;
        total++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata got=%h exp=0", rsp_rdata); else passed++;
        total++; if ({psel, penable} !== 2'b00) $display("FAIL wr_drop_psel got=%b exp=00", {psel, penable}); else passed++;
        rsp_ready = 1'b1;
        @(negedge hclk);                                   // cycle 4
        rsp_ready = 1'b0;
        total++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL wr_c4_idle got=%b exp=10", {req_ready, rsp_valid}); else passed++;
    endtask

    task automatic test_read_wait();
        @(negedge hclk);
        issue(1'b0, 32'h04, 32'hFFFF_FFFF, 4'hF, 3'b000);
        @(negedge hclk);                                   // SETUP
        req_valid = 1'b0;
        total++; if ({psel, penable} !== 2'b10) $display("FAIL rd_setup_pattern got=%b exp=10", {psel, penable}); else passed++;
        for (int i = 0; i < 4; i++) begin                  // four ACCESS cycles
            @(negedge hclk);
            total++; if ({psel, penable, pwrite} !== 3'b110 || paddr !== 32'h04 || pstrb !== 4'h0 || pwdata !== 32'h0)
                $display("FAIL rd_access_stable[%0d] got=%b/%h/%h/%h exp=110/00000004/0/0", i,
                         {psel, penable, pwrite}, paddr, pstrb, pwdata); else passed++;
            total++; if (rsp_valid !== 1'b0) $display("FAIL rd_early_rsp[%0d] got=%0h exp=0", i, rsp_valid); else passed++;
            pready = (i == 3);
            prdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0000 + i;
        end
        @(negedge hclk);
        pready = 1'b0;
        total++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid got=%0h exp=1", rsp_valid); else passed++;
        total++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rsp_rdata got=%h exp=deadbeef", rsp_rdata); else passed++;
        total++; if ({rsp_err, rsp_timeout} !== 2'b00) $display("FAIL rd_rsp_err got=%b exp=00", {rsp_err, rsp_timeout}); else passed++;
        rsp_ready = 1'b1;
        @(negedge hclk);
        rsp_ready = 1'b0;
        total++; if (req_ready !== 1'b1) $display("FAIL rd_back_idle got=%0h exp=1", req_ready); else passed++;
    endtask

    task automatic test_slverr();
        @(negedge hclk);
        issue(1'b0, 32'h08, 32'h5555_AAAA, 4'hF, 3'b001);
        @(negedge hclk);                                   // SETUP
        req_valid = 1'b0;
        total++; if (pstrb !== 4'h0) $display("FAIL err_setup_pstrb got=%h exp=0", pstrb); else passed++;
        @(negedge hclk);                                   // ACCESS
        total++; if (pstrb !== 4'h0 || penable !== 1'b1) $display("FAIL err_access_pstrb got=%h/%0h exp=0/1", pstrb, penable); else passed++;
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hCAFE_F00D;
        @(negedge hclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110)
            $display("FAIL err_rsp_flags got=%b exp=110", {rsp_valid, rsp_err, rsp_timeout}); else passed++;
        total++; if (rsp_rdata !== 32'h0) $display("FAIL err_rsp_rdata got=%h exp=0", rsp_rdata); else passed++;
        rsp_ready = 1'b1;
        @(negedge hclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        @(negedge hclk);
        issue(1'b1, 32'h40, 32'h0000_0001, 4'h3, 3'b000);
        @(negedge hclk);                                   // SETUP
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin                  // ACCESS cycles 1..8
            @(negedge hclk);
            total++; if ({psel, penable, rsp_valid} !== 3'b110)
                $display("FAIL to_access[%0d] got=%b exp=110", i, {psel, penable, rsp_valid}); else passed++;
        end
        @(negedge hclk);
        total++; if ({psel, penable} !== 2'b00) $display("FAIL to_psel_drop got=%b exp=00", {psel, penable}); else passed++;
        total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111)
            $display("FAIL to_rsp_flags got=%b exp=111", {rsp_valid, rsp_err, rsp_timeout}); else passed++;
        total++; if (rsp_rdata !== 32'h0) $display("FAIL to_rsp_rdata got=%h exp=0", rsp_rdata); else passed++;
        rsp_ready = 1'b1;
        @(negedge hclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        @(negedge hclk);
        issue(1'b0, 32'h13, 32'h0, 4'h0, 3'b000);
        @(negedge hclk);                                   // one cycle after accept
        // Keep a new request pending: it must be ignored while busy.
        issue(1'b1, 32'h20, 32'h1111_1111, 4'hF, 3'b000);
        total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110)
            $display("FAIL mis_rsp_flags got=%b exp=110", {rsp_valid, rsp_err, rsp_timeout}); else passed++;
        total++; if (rsp_rdata !== 32'h0) $display("FAIL mis_rsp_rdata got=%h exp=0", rsp_rdata); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, rsp_err, req_ready, psel} !== 4'b1100)
                $display("FAIL mis_hold[%0d] got=%b exp=1100", i, {rsp_valid, rsp_err, req_ready, psel}); else passed++;
            @(negedge hclk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge hclk);
        rsp_ready = 1'b0;
        total++; if ({req_ready, rsp_valid, psel} !== 3'b100)
            $display("FAIL mis_release got=%b exp=100", {req_ready, rsp_valid, psel}); else passed++;
    endtask

    task automatic test_reset_mid_access();
        @(negedge hclk);
        issue(1'b0, 32'h24, 32'h0, 4'h0, 3'b000);
        @(negedge hclk);                                   // SETUP
        req_valid = 1'b0;
        @(negedge hclk);                                   // ACCESS 1
        @(negedge hclk);                                   // ACCESS 2
        total++; if ({psel, penable} !== 2'b11) $display("FAIL rma_pre got=%b exp=11", {psel, penable}); else passed++;
        hrst = 1'b1;
        @(negedge hclk);
        hrst   = 1'b0;
        pready = 1'b1;                                     // must be ignored in IDLE
        prdata = 32'hFEED_FACE;
        total++; if ({psel, penable, rsp_valid, req_ready} !== 4'b0001)
            $display("FAIL rma_after got=%b exp=0001", {psel, penable, rsp_valid, req_ready}); else passed++;
        total++; if (paddr !== 32'h0) $display("FAIL rma_paddr got=%h exp=0", paddr); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            total++; if ({rsp_valid, psel, req_ready} !== 3'b001)
                $display("FAIL rma_spurious[%0d] got=%b exp=001", i, {rsp_valid, psel, req_ready}); else passed++;
        end
        pready = 1'b0;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        hrst      = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_misaligned();
        test_reset_mid_access();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_apb4_master_bridge
`default_nettype wire
